alu_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_datapath.sv | 76 +++++++
 rtl/alu_unit.sv | 40 ++++
 tb/tb_alu_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes and fixed constants.
package alu_pkg;

   // Operation select codes, one per alu_sel value; every 4-bit code is a defined op.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_MUL  = 4'd2,
      ALU_DIV  = 4'd3,
      ALU_SHL  = 4'd4,
      ALU_SHR  = 4'd5,
      ALU_ROL  = 4'd6,
      ALU_ROR  = 4'd7,
      ALU_AND  = 4'd8,
      ALU_OR   = 4'd9,
      ALU_XOR  = 4'd10,
      ALU_NOR  = 4'd11,
      ALU_NAND = 4'd12,
      ALU_XNOR = 4'd13,
      ALU_GT   = 4'd14,
      ALU_EQ   = 4'd15
   } alu_op_e;

   // Result forced onto alu_out when dividing by zero (carry is raised alongside).
   localparam logic [7:0] DIV0_RESULT = 8'hFF;

   // Result/flag pair produced by the combinational datapath.
   typedef struct packed {
      logic       carry;
      logic [7:0] res;
   } alu_result_t;

endpackage : alu_pkg

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: (a, b, op) -> (res, carry). No state, no clock.
import alu_pkg::*;

module alu_datapath (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  alu_op_e    op,
   output logic [7:0] res,
   output logic       carry
);

   logic [8:0]  sum_ext;    // 9-bit sum, bit 8 is the carry
   logic [8:0]  diff_ext;   // 9-bit difference, bit 8 is the borrow (a < b)
   logic [15:0] prod;       // full product, upper byte flags overflow
   logic [7:0]  divisor;    // b with zero replaced so the divider never sees 0
   logic [7:0]  quotient;
   logic        div_by_zero;

   // Shared arithmetic terms computed once, selected below.
   always_comb begin
      sum_ext     = {1'b0, a} + {1'b0, b};
      diff_ext    = {1'b0, a} - {1'b0, b};
      prod        = {8'h00, a} * {8'h00, b};
      div_by_zero = (b == 8'h00);
      divisor     = div_by_zero ? 8'h01 : b;
      quotient    = a / divisor;
   end

   // Operation select: pick the result and flag for the requested op.
   always_comb begin
      // NOTE: defaults first so every path assigns res/carry and no latch is inferred.
      res   = 8'h00;
      carry = 1'b0;
      unique case (op)
         ALU_ADD: begin
            res   = sum_ext[7:0];
            carry = sum_ext[8];
         end
         ALU_SUB: begin
            res   = diff_ext[7:0];
            carry = diff_ext[8];
         end
         ALU_MUL: begin
            res   = prod[7:0];
            carry = |prod[15:8];
         end
         ALU_DIV: begin
            res   = div_by_zero ? DIV0_RESULT : quotient;
            carry = div_by_zero;
         end
         ALU_SHL: begin
            res   = {a[6:0], 1'b0};
            carry = a[7];
         end
         ALU_SHR: begin
            res   = {1'b0, a[7:1]};
            carry = a[0];
         end
         ALU_ROL:  res = {a[6:0], a[7]};
         ALU_ROR:  res = {a[0], a[7:1]};
         ALU_AND:  res = a & b;
         ALU_OR:   res = a | b;
         ALU_XOR:  res = a ^ b;
         ALU_NOR:  res = ~(a | b);
         ALU_NAND: res = ~(a & b);
         ALU_XNOR: res = ~(a ^ b);
         ALU_GT:   res = {7'b0, (a > b)};
         ALU_EQ:   res = {7'b0, (a == b)};
         default: begin
            res   = 8'h00;
            carry = 1'b0;
         end
      endcase
   end

endmodule : alu_datapath

// File: rtl/alu_unit.sv
// Execute-stage ALU: combinational datapath followed by a one-cycle output register.
import alu_pkg::*;

module alu_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] alu_sel,
   output logic [7:0] alu_out,
   output logic       carry_out
);

   alu_op_e     op;
   alu_result_t next_q;

   // Every 4-bit select value maps onto a defined operation code.
   assign op = alu_op_e'(alu_sel);

   alu_datapath u_datapath (
      .a     (a),
      .b     (b),
      .op    (op),
      .res   (next_q.res),
      .carry (next_q.carry)
   );

   // Output register: clears asynchronously, loads a new result every rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out   <= 8'h00;
         carry_out <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep register updates race-free across blocks.
         alu_out   <= next_q.res;
         carry_out <= next_q.carry;
      end
   end

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed steps, reset behaviour, random vs model.
`timescale 1ns/1ps

module tb_alu_unit;

   logic       clk;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] alu_sel;
   logic [7:0] alu_out;
   logic       carry_out;

   int n_checks;
   int n_fail;

   alu_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model from the op table, using plain integer arithmetic.
   // Returns {carry, result}.
   function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [3:0] msel);
      int ia, ib, r, c;
      logic [7:0] va, vb, vr;
      ia = int'(ma);
      ib = int'(mb);
      va = ma;
      vb = mb;
      r  = 0;
      c  = 0;
      vr = 8'h00;
      case (int'(msel))
         0:  begin r = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
         1:  begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
         2:  begin r = (ia * ib) % 256; c = (ia * ib > 255) ? 1 : 0; end
         3:  begin
                if (ib == 0) begin r = 255; c = 1; end
                else         begin r = ia / ib; c = 0; end
             end
         4:  begin r = (ia * 2) % 256; c = (ia >= 128) ? 1 : 0; end
         5:  begin r = ia / 2; c = ia % 2; end
         6:  r = (ia * 2) % 256 + ia / 128;
         7:  r = ia / 2 + (ia % 2) * 128;
         8:  begin vr = va & vb;    r = int'(vr); end
         9:  begin vr = va | vb;    r = int'(vr); end
         10: begin vr = va ^ vb;    r = int'(vr); end
         11: begin vr = ~(va | vb); r = int'(vr); end
         12: begin vr = ~(va & vb); r = int'(vr); end
         13: begin vr = ~(va ^ vb); r = int'(vr); end
         14: r = (ia > ib) ? 1 : 0;
         default: r = (ia == ib) ? 1 : 0;
      endcase
      return {c[0], r[7:0]};
   endfunction

   // One comparison of the registered outputs against an expected {carry, result}.
   task automatic check(input string tag, input logic [7:0] exp_out, input logic exp_c);
      n_checks++;
      assert ({carry_out, alu_out} === {exp_c, exp_out})
      else begin
         n_fail++;
         $error("FAIL %s: observed out=%h carry=%b, expected out=%h carry=%b",
                tag, alu_out, carry_out, exp_out, exp_c);
      end
   endtask

   // Drive one op away from the edge, let the edge register it, sample just after.
   task automatic step(input logic [7:0] sa, input logic [7:0] sb, input logic [3:0] ssel);
      @(negedge clk);
      a       = sa;
      b       = sb;
      alu_sel = ssel;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      tag;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
      logic [7:0] out;
      logic       c;
   } vec_t;

   vec_t vecs[$];
   logic [8:0] exp_v;

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Reset held while the clock runs: outputs stay cleared.
      rst_n   = 1'b0;
      a       = 8'h55;
      b       = 8'h0F;
      alu_sel = 4'd0;
      repeat (4) begin
         @(posedge clk);
         #1;
         check("reset_hold", 8'h00, 1'b0);
      end

      // Release: first edge afterwards loads 0x55+0x0F.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_release", 8'h64, 1'b0);

      // Directed op table cases, including wrap-around and divide-by-zero.
      vecs = '{
         '{"add_carry",  8'hF0, 8'h20, 4'd0,  8'h10, 1'b1},
         '{"add_plain",  8'h12, 8'h34, 4'd0,  8'h46, 1'b0},
         '{"add_wrap",   8'hFF, 8'h01, 4'd0,  8'h00, 1'b1},
         '{"sub_borrow", 8'h05, 8'h07, 4'd1,  8'hFE, 1'b1},
         '{"sub_wrap",   8'h00, 8'h01, 4'd1,  8'hFF, 1'b1},
         '{"mul_ovf",    8'h10, 8'h11, 4'd2,  8'h10, 1'b1},
         '{"mul_plain",  8'h03, 8'h04, 4'd2,  8'h0C, 1'b0},
         '{"div_plain",  8'h64, 8'h07, 4'd3,  8'h0E, 1'b0},
         '{"div_zero",   8'h64, 8'h00, 4'd3,  8'hFF, 1'b1},
         '{"shl",        8'h81, 8'h00, 4'd4,  8'h02, 1'b1},
         '{"shr",        8'h81, 8'h00, 4'd5,  8'h40, 1'b1},
         '{"rol",        8'h81, 8'h00, 4'd6,  8'h03, 1'b0},
         '{"ror",        8'h81, 8'h00, 4'd7,  8'hC0, 1'b0},
         '{"and",        8'hCC, 8'hAA, 4'd8,  8'h88, 1'b0},
         '{"or",         8'hCC, 8'hAA, 4'd9,  8'hEE, 1'b0},
         '{"xor",        8'hCC, 8'hAA, 4'd10, 8'h66, 1'b0},
         '{"nor",        8'hCC, 8'hAA, 4'd11, 8'h11, 1'b0},
         '{"nand",       8'hCC, 8'hAA, 4'd12, 8'h77, 1'b0},
         '{"xnor",       8'hCC, 8'hAA, 4'd13, 8'h99, 1'b0},
         '{"eq_true",    8'h5A, 8'h5A, 4'd15, 8'h01, 1'b0},
         '{"gt_equal",   8'h5A, 8'h5A, 4'd14, 8'h00, 1'b0},
         '{"gt_true",    8'h5B, 8'h5A, 4'd14, 8'h01, 1'b0},
         '{"eq_false",   8'h5B, 8'h5A, 4'd15, 8'h00, 1'b0}
      };
      foreach (vecs[i]) begin
         step(vecs[i].a, vecs[i].b, vecs[i].sel);
         check(vecs[i].tag, vecs[i].out, vecs[i].c);
      end

      // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
      step(8'hF0, 8'h20, 4'd0);
      check("pre_async", 8'h10, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clear", 8'h00, 1'b0);
      @(negedge clk);
      a       = 8'h03;
      b       = 8'h04;
      alu_sel = 4'd2;
      rst_n   = 1'b1;
      @(posedge clk);
      #1;
      check("async_release", 8'h0C, 1'b0);

      // Back-to-back random ops, one per cycle, against the model.
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic [3:0] rs;
         ra = 8'($urandom_range(0, 255));
         rb = (($urandom_range(0, 15)) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         rs = 4'($urandom_range(0, 15));
         step(ra, rb, rs);
         exp_v = model(ra, rb, rs);
         check($sformatf("rand%0d_sel%0d_a%h_b%h", i, rs, ra, rb), exp_v[7:0], exp_v[8]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_alu_unit
